// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for a multicycle MIPS-style datapath.
//                Sequences fetch / decode / execute / memory / write-back
//                steps and drives the datapath strobes and selects. Memory
//                states wait on MemReady and are bounded by a timeout.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                Opcode[5:0]           - IR[31:26], valid from DECODE on
//                MemReady              - memory access completes when high
//                PCWrite .. BranchNe   - 1-bit datapath strobes / selects
//                AluSrcB, PCSource,
//                AluOp [1:0]           - datapath mux selects / ALU op class
//                MemErr, IllegalOp     - one-cycle error pulses
//                State[3:0]            - current state, for debug
//  Config      : MC_ILLEGAL_HALT_EN - when defined, an illegal opcode parks
//                the FSM in HALT until reset; otherwise it returns to FETCH.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       AluSrcA,
  output logic       BranchNe,
  output logic [1:0] AluSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] AluOp,
  output logic       MemErr,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wait_st;
  logic       timeout;

  // Only these three states wait on the memory handshake.
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // A same-cycle MemReady wins over the timeout.
  assign timeout = wait_st && !MemReady && (cnt_q == C_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter clears on any state change and on timeout (FETCH->FETCH).
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || timeout) begin
      cnt_d = 8'd0;
    end else if (wait_st && !MemReady) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    AluSrcA     = 1'b0;
    BranchNe    = 1'b0;
    AluSrcB     = 2'b00;
    PCSource    = 2'b00;
    AluOp       = 2'b00;
    MemErr      = 1'b0;
    IllegalOp   = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady)     state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        AluSrcB = 2'b11;
        case (Opcode)
          C_OP_LW, C_OP_SW:   state_d = S_MEMADR;
          C_OP_RTYPE:         state_d = S_EXEC;
          C_OP_BEQ, C_OP_BNE: state_d = S_BRANCH;
          C_OP_ADDI:          state_d = S_ADDIEX;
          C_OP_J:             state_d = S_JUMP;
          default: begin
            IllegalOp = 1'b1;
`ifdef MC_ILLEGAL_HALT_EN
            state_d = S_HALT;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = (Opcode == C_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)     state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady || timeout) state_d = S_FETCH;
      end
      S_EXEC: begin
        AluSrcA = 1'b1;
        AluOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNe    = (Opcode == C_OP_BNE);
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    MemErr = timeout;

    // Outputs are forced quiet the moment reset asserts, before the
    // asynchronous state reset is visible to the decode.
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      AluSrcA     = 1'b0;
      BranchNe    = 1'b0;
      AluSrcB     = 2'b00;
      PCSource    = 2'b00;
      AluOp       = 2'b00;
      MemErr      = 1'b0;
      IllegalOp   = 1'b0;
    end
  end

  assign State = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. Instructions are
//                expanded into their expected per-cycle state path (including
//                memory wait cycles); strobes per state come from the opcode
//                step table. Random instruction mix plus directed timeout,
//                reset-abort and illegal-opcode sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, AluSrcA, BranchNe;
  logic [1:0] AluSrcB, PCSource, AluOp;
  logic       MemErr, IllegalOp;
  logic [3:0] State;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .AluSrcA(AluSrcA), .BranchNe(BranchNe), .AluSrcB(AluSrcB),
    .PCSource(PCSource), .AluOp(AluOp), .MemErr(MemErr),
    .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] dut_vec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            RegWrite, RegDst, AluSrcA, BranchNe, AluSrcB, PCSource, AluOp};
  endfunction

  // Strobes expected in each numbered step of the instruction table.
  function automatic logic [16:0] exp_vec(input int st, input bit mr, input logic [5:0] op);
    bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
    bit rw = 0, rd = 0, asa = 0, bne = 0;
    bit [1:0] asb = 0, pcs = 0, aop = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = (op == BNE); end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, bne, asb, pcs, aop};
  endfunction

  task automatic check(input int st, input logic [16:0] ev, input bit err, input bit ill);
    tests++;
    assert (State === 4'(st)) else begin
      fails++; $error("FAIL state: observed %0d expected %0d", State, st);
    end
    tests++;
    assert (dut_vec() === ev) else begin
      fails++; $error("FAIL strobes(st=%0d): observed %b expected %b", st, dut_vec(), ev);
    end
    tests++;
    assert (MemErr === err) else begin
      fails++; $error("FAIL MemErr(st=%0d): observed %b expected %b", st, MemErr, err);
    end
    tests++;
    assert (IllegalOp === ill) else begin
      fails++; $error("FAIL IllegalOp(st=%0d): observed %b expected %b", st, IllegalOp, ill);
    end
  endtask

  // One clock cycle: drive MemReady, check mid-cycle, advance past the edge.
  task automatic cyc(input int st, input bit mr, input bit err, input bit ill);
    MemReady = mr;
    @(negedge clk);
    check(st, exp_vec(st, mr, Opcode), err, ill);
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, BNE, ADDI, JMP};
  endfunction

  // Expected path of one instruction: FETCH with wf waits, DECODE, then the
  // instruction's steps, with wm waits in the memory access step.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    Opcode = op;
    for (int i = 0; i < wf; i++) cyc(0, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(1, 1'($urandom), 1'b0, !is_legal(op));
    case (op)
      LW: begin
        cyc(2, 1'($urandom), 0, 0);
        for (int i = 0; i < wm; i++) cyc(3, 1'b0, 0, 0);
        cyc(3, 1'b1, 0, 0);
        cyc(4, 1'($urandom), 0, 0);
      end
      SW: begin
        cyc(2, 1'($urandom), 0, 0);
        for (int i = 0; i < wm; i++) cyc(5, 1'b0, 0, 0);
        cyc(5, 1'b1, 0, 0);
      end
      RT:       begin cyc(6, 1'($urandom), 0, 0); cyc(7, 1'($urandom), 0, 0); end
      BEQ, BNE: cyc(8, 1'($urandom), 0, 0);
      ADDI:     begin cyc(9, 1'($urandom), 0, 0); cyc(10, 1'($urandom), 0, 0); end
      JMP:      cyc(11, 1'($urandom), 0, 0);
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
    ops[4] = BNE; ops[5] = ADDI; ops[6] = JMP;

    // Reset: everything quiet even with MemReady high in FETCH.
    rst_n = 1'b0; MemReady = 1'b1;
    #3;
    check(0, 17'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check(0, 17'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // lw with MemReady held high: 0,1,2,3,4 then back to 0.
    run_instr(LW, 0, 0);
    // sw with three MEMWR waits.
    run_instr(SW, 0, 3);
    run_instr(BNE, 0, 0);
    run_instr(BEQ, 0, 0);

    // FETCH timeout: MemErr exactly at the 16th waiting cycle, IRWrite never.
    Opcode = JMP;
    for (int i = 0; i < 20; i++) cyc(0, 1'b0, i == 15, 1'b0);
    cyc(0, 1'b1, 0, 0);
    cyc(1, 1'b0, 0, 0);
    cyc(11, 1'b0, 0, 0);

    // MemReady arriving on the timeout cycle completes normally.
    run_instr(ADDI, 15, 0);
    run_instr(LW, 0, 15);

    // MEMWR timeout aborts back to FETCH.
    Opcode = SW;
    cyc(0, 1'b1, 0, 0);
    cyc(1, 1'b0, 0, 0);
    cyc(2, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(5, 1'b0, i == 15, 1'b0);
    cyc(0, 1'b0, 0, 0);
    cyc(0, 1'b1, 0, 0);
    cyc(1, 1'b0, 0, 0);
    cyc(2, 1'b0, 0, 0);
    cyc(5, 1'b1, 0, 0);

    // Randomised instruction mix.
    for (int n = 0; n < 30; n++) begin
      op = ops[$urandom_range(0, 6)];
`ifndef MC_ILLEGAL_HALT_EN
      if ($urandom_range(0, 5) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
`endif
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Reset in RWB: strobes drop at once, and restart is from FETCH.
    Opcode = RT;
    cyc(0, 1'b1, 0, 0);
    cyc(1, 1'b1, 0, 0);
    cyc(6, 1'b1, 0, 0);
    #1 rst_n = 1'b0;
    #1 check(0, 17'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check(0, 17'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(0, 1'b0, 0, 0);
    run_instr(LW, 0, 0);

    // Illegal opcode.
    run_instr(6'b111111, 0, 0);
`ifdef MC_ILLEGAL_HALT_EN
    for (int i = 0; i < 4; i++) cyc(12, 1'($urandom), 0, 0);
`else
    cyc(0, 1'b0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15; maximum wait cycles for MemReady in any memory state (legal range 1..255).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Opcode  input  6  IR[31:26], valid from DECODE onward.
REQ-005 MemReady  input  1  memory handshake; access completes in the cycle it is high.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, AluSrcA, BranchNe  output  1 each  datapath strobes and selects.
REQ-007 AluSrcB  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = shifted sign-extended imm.
REQ-008 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-009 AluOp  output  2  to ALU control decoder: 00 = add, 01 = subtract, 10 = R-type function field.
REQ-010 MemErr  output  1  one-cycle pulse on memory timeout.
REQ-011 IllegalOp  output  1  one-cycle pulse on unsupported opcode.
REQ-012 State  output  4  current state encoding, for debug.

Function
REQ-013 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
REQ-014 All outputs SHALL be combinational decodes of the State register, plus MemReady in the memory states; any strobe not listed for a state SHALL be 0.
REQ-015 FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSource=00. IRWrite=1 and PCWrite=1 only while MemReady=1. When MemReady=1, go to DECODE; otherwise stay.
REQ-016 DECODE: AluSrcA=0, AluSrcB=11, AluOp=00. Next state by Opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 or 000101 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> illegal handling (REQ-027).
REQ-017 MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Next state is MEMRD for 100011 and MEMWR for 101011.
REQ-018 MEMRD: MemRead=1, IorD=1. Go to MEMWB when MemReady=1.
REQ-019 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1. Go to FETCH when MemReady=1.
REQ-021 EXEC: AluSrcA=1, AluSrcB=00, AluOp=10. Next state RWB. RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
REQ-022 BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01; BranchNe=1 iff Opcode=000101. Next state FETCH.
REQ-023 ADDIEX: AluSrcA=1, AluSrcB=10, AluOp=00. Next state ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10. Next state FETCH.
REQ-025 Wait counter (8-bit) SHALL clear on every state change and increment each cycle spent in FETCH, MEMRD or MEMWR with MemReady=0.
REQ-026 Timeout: when the counter equals MEM_TIMEOUT and MemReady=0, MemErr=1 for that cycle and the next state is FETCH, with the counter cleared. MemReady=1 in the same cycle takes priority and completes normally.
REQ-027 Illegal opcode in DECODE: IllegalOp=1 for that cycle; the next state is set by REQ-033.
REQ-028 Instruction latency without waits: lw=5, sw=4, R-type=4, addi=4, beq/bne=3, j=3 cycles.

Reset
REQ-029 While rst_n=0, State SHALL be FETCH, the wait counter 0, and every output strobe 0, including IRWrite, PCWrite and MemRead.
REQ-030 Reset asserted mid-instruction SHALL abort immediately with no further write strobes.
REQ-031 After rst_n deasserts, the first rising edge SHALL evaluate from FETCH.

Configuration
REQ-032 Macro MC_ILLEGAL_HALT_EN controls illegal-opcode handling.
REQ-033 With MC_ILLEGAL_HALT_EN defined: an illegal opcode goes to HALT, where all strobes are 0 and the block stays until reset. Without it: next state is FETCH and HALT is unreachable.

Verification
REQ-034 Reset, then lw (100011) with MemReady held 1: State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-035 sw (101011) with MemReady low for 3 cycles in MEMWR: State stays 5 for 4 cycles; MemWrite=1 throughout; returns to 0; MemErr stays 0.
REQ-036 MemReady held 0 in FETCH with MEM_TIMEOUT=15: MemErr pulses once, 16 cycles after entering FETCH; IRWrite never 1.
REQ-037 bne (000101): State 0,1,8,0; PCWriteCond=1 and BranchNe=1 in state 8. beq (000100): BranchNe=0.
REQ-038 Opcode 111111: IllegalOp pulses once in DECODE. Next state is 12 and stays there with the macro defined, 0 without it.
REQ-039 rst_n pulled low while in RWB: outputs go to 0 immediately; after release, State=0 and no RegWrite is seen.
